// File: rtl/fpu_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_sequencer
// Brief    : Sequences one FP instruction from the core through RF read, the
//            shared execution unit and write-back; keeps sticky IEEE flags.
//            Optional EXEC watchdog enabled by defining FPU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [2:0]       issue_op,
    input  logic [4:0]       issue_fs,
    input  logic [4:0]       issue_ft,
    input  logic [4:0]       issue_fd,
    output logic             stall,
    output logic [4:0]       rf_ra1,
    output logic [4:0]       rf_ra2,
    input  logic [WIDTH-1:0] rf_rd1,
    input  logic [WIDTH-1:0] rf_rd2,
    output logic             rf_we,
    output logic [4:0]       rf_wa,
    output logic [WIDTH-1:0] rf_wd,
    output logic             eu_start,
    output logic [2:0]       eu_op,
    output logic [WIDTH-1:0] eu_a,
    output logic [WIDTH-1:0] eu_b,
    input  logic             eu_done,
    input  logic [WIDTH-1:0] eu_result,
    input  logic [4:0]       eu_flags,
    input  logic             flags_clr,
    output logic             fcc,
    output logic [4:0]       sticky_flags,
    output logic             err_illegal
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_READ = 2'd1;
    localparam logic [1:0] c_EXEC = 2'd2;
    localparam logic [1:0] c_WB   = 2'd3;

    localparam logic [2:0] c_OP_MOV = 3'b100;
    localparam logic [2:0] c_OP_CMP = 3'b101;

    if (WIDTH < 1 || TIMEOUT < 1) begin : g_param_check
        $error("fpu_issue_sequencer: WIDTH and TIMEOUT must be >= 1");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [2:0]       r_op;
    logic [4:0]       r_fs;
    logic [4:0]       r_ft;
    logic [4:0]       r_fd;
    logic [WIDTH-1:0] r_eu_a;
    logic [WIDTH-1:0] r_eu_b;
    logic             r_eu_start;
    logic [WIDTH-1:0] r_result;
    logic             r_fcc;
    logic [4:0]       r_sticky;
    logic             r_err;

    logic             w_issue_illegal;
    logic             w_lat_illegal;
    logic             w_lat_writes;
    logic             w_timeout;
    logic             w_aborted;
    logic [4:0]       w_flag_set;
    logic             w_err_set;

    assign w_issue_illegal = (issue_op[2:1] == 2'b11);
    assign w_lat_illegal   = (r_op[2:1] == 2'b11);
    // add/sub/mul/div/mov are the ops that write the destination register
    assign w_lat_writes    = (r_op <= c_OP_MOV);

`ifdef FPU_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_aborted;

    assign w_timeout = (r_state == c_EXEC) && !eu_done &&
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));
    assign w_aborted = r_aborted;

    // Counter sits at zero outside EXEC, so it restarts on every EXEC entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_aborted <= 1'b0;
        end else begin
            if (r_state == c_EXEC) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            r_aborted <= w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_aborted = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (issue_valid) begin
                    w_next_state = c_READ;
                end
            end
            c_READ: begin
                if ((r_op == c_OP_MOV) || w_lat_illegal) begin
                    w_next_state = c_WB;
                end else begin
                    w_next_state = c_EXEC;
                end
            end
            c_EXEC: begin
                if (eu_done || w_timeout) begin
                    w_next_state = c_WB;
                end
            end
            c_WB:    w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        stall  = 1'b0;
        rf_ra1 = r_fs;
        rf_ra2 = r_ft;
        rf_we  = 1'b0;
        rf_wa  = r_fd;
        rf_wd  = r_result;
        case (r_state)
            c_IDLE: begin
                stall  = issue_valid;
                rf_ra1 = issue_fs;
                rf_ra2 = issue_ft;
            end
            c_READ: stall = 1'b1;
            c_EXEC: stall = 1'b1;
            c_WB:   rf_we = w_lat_writes && !w_aborted;
            default: stall = 1'b0;
        endcase
    end

    assign eu_start     = r_eu_start;
    assign eu_op        = r_op;
    assign eu_a         = r_eu_a;
    assign eu_b         = r_eu_b;
    assign fcc          = r_fcc;
    assign sticky_flags = r_sticky;
    assign err_illegal  = r_err;

    // ------------------------------------------------------------------
    // Instruction latch, operand capture and result path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= '0;
            r_fs       <= '0;
            r_ft       <= '0;
            r_fd       <= '0;
            r_eu_a     <= '0;
            r_eu_b     <= '0;
            r_eu_start <= 1'b0;
            r_result   <= '0;
            r_fcc      <= 1'b0;
        end else begin
            r_eu_start <= (r_state == c_READ) && (w_next_state == c_EXEC);
            case (r_state)
                c_IDLE: begin
                    if (issue_valid) begin
                        r_op <= issue_op;
                        r_fs <= issue_fs;
                        r_ft <= issue_ft;
                        r_fd <= issue_fd;
                    end
                end
                c_READ: begin
                    // Operands are frozen here, so fd == fs is safe at WB
                    r_eu_a <= rf_rd1;
                    r_eu_b <= rf_rd2;
                    if (r_op == c_OP_MOV) begin
                        r_result <= rf_rd1;
                    end
                end
                c_EXEC: begin
                    if (eu_done) begin
                        r_result <= eu_result;
                    end
                end
                c_WB: begin
                    if ((r_op == c_OP_CMP) && !w_aborted) begin
                        r_fcc <= r_result[0];
                    end
                end
                default: r_fcc <= r_fcc;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky exception flags: a clear never masks same-cycle new flags
    // ------------------------------------------------------------------
    always_comb begin
        w_flag_set = 5'b0;
        if ((r_state == c_EXEC) && eu_done) begin
            w_flag_set = eu_flags;
        end
        if (w_timeout) begin
            w_flag_set[4] = 1'b1;
        end
    end

    assign w_err_set = ((r_state == c_IDLE) && issue_valid && w_issue_illegal) ||
                       w_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= 5'b0;
            r_err    <= 1'b0;
        end else begin
            r_sticky <= (flags_clr ? 5'b0 : r_sticky) | w_flag_set;
            r_err    <= (flags_clr ? 1'b0 : r_err) | w_err_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_sequencer.sv
`default_nettype none
// Testbench for fpu_issue_sequencer: directed instructions, an FP register
// file and EU model, and a scoreboard for EU starts and RF writes.
module tb_fpu_issue_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [4:0]  issue_fs, issue_ft, issue_fd;
    logic        stall;
    logic [4:0]  rf_ra1, rf_ra2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        eu_start;
    logic [2:0]  eu_op;
    logic [31:0] eu_a, eu_b;
    logic        eu_done;
    logic [31:0] eu_result;
    logic [4:0]  eu_flags;
    logic        flags_clr;
    logic        fcc;
    logic [4:0]  sticky_flags;
    logic        err_illegal;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } eu_txn_t;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_txn_t;

    eu_txn_t eu_q[$];
    wr_txn_t wr_q[$];

    logic [31:0] rf [32];

    fpu_issue_sequencer #(.WIDTH(32), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_fs(issue_fs), .issue_ft(issue_ft), .issue_fd(issue_fd),
        .stall(stall), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .eu_start(eu_start), .eu_op(eu_op), .eu_a(eu_a), .eu_b(eu_b),
        .eu_done(eu_done), .eu_result(eu_result), .eu_flags(eu_flags),
        .flags_clr(flags_clr), .fcc(fcc),
        .sticky_flags(sticky_flags), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    assign rf_rd1 = rf[rf_ra1];
    assign rf_rd2 = rf[rf_ra2];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 + 32'(i);
            rf[1] <= 32'h3F80_0000;
            rf[2] <= 32'h4000_0000;
        end else if (rf_we) begin
            rf[rf_wa] <= rf_wd;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT starts the EU or writes
    always @(negedge clk) begin
        if (!reset) begin
            if (eu_start) begin
                if (eu_q.size() == 0) begin
                    chk("unexpected_eu_start", 32'(eu_start), 32'd0);
                end else begin
                    eu_txn_t e;
                    e = eu_q.pop_front();
                    chk("eu_op", 32'(eu_op), 32'(e.op));
                    chk("eu_a", eu_a, e.a);
                    chk("eu_b", eu_b, e.b);
                end
            end
            if (rf_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_rf_we", 32'(rf_we), 32'd0);
                end else begin
                    wr_txn_t w;
                    w = wr_q.pop_front();
                    chk("rf_wa", 32'(rf_wa), 32'(w.wa));
                    chk("rf_wd", rf_wd, w.wd);
                end
            end
        end
    end

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [4:0] fs, input logic [4:0] ft, input logic [4:0] fd,
                       input int n, input logic [31:0] res, input logic [4:0] fl,
                       input logic clr, input int exp_stall, input int exp_start,
                       input int exp_we, input logic [31:0] exp_a,
                       input logic [31:0] exp_b, input logic [31:0] exp_wd);
        int  stall_cnt = 0;
        int  start_cnt = 0;
        int  we_cnt    = 0;
        int  since     = 0;
        bit  busy      = 0;
        bit  done      = 0;
        if (exp_start == 1) eu_q.push_back('{op, exp_a, exp_b});
        if (exp_we == 1)    wr_q.push_back('{fd, exp_wd});
        @(posedge clk); #1;
        issue_valid = 1'b1; issue_op = op;
        issue_fs = fs; issue_ft = ft; issue_fd = fd;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (rf_we) we_cnt++;
            if (eu_start) begin
                start_cnt++;
                busy  = 1;
                since = 0;
            end
            if (busy) begin
                if (since == n - 1) begin
                    eu_done = 1'b1; eu_result = res; eu_flags = fl; flags_clr = clr;
                    busy = 0;
                end else begin
                    since++;
                end
            end
            if (c > 1 && !stall) done = 1;
            @(posedge clk); #1;
            issue_valid = 1'b0; eu_done = 1'b0; eu_flags = 5'b0; flags_clr = 1'b0;
        end
        chk({tag, "_completed"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        chk({tag, "_eu_starts"}, 32'(start_cnt), 32'(exp_start));
        chk({tag, "_rf_we_cycles"}, 32'(we_cnt), 32'(exp_we));
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 flags_clr = 1'b1;
        @(posedge clk); #1 flags_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        issue_valid = 1'b0; issue_op = 3'b0;
        issue_fs = 5'd7; issue_ft = 5'd9; issue_fd = 5'd0;
        eu_done = 1'b0; eu_result = 32'h0; eu_flags = 5'b0; flags_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_eu_start", 32'(eu_start), 32'd0);
        chk("rst_fcc", 32'(fcc), 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_eu_a", eu_a, 32'd0);
        chk("idle_ra1_passthru", 32'(rf_ra1), 32'd7);
        chk("idle_ra2_passthru", 32'(rf_ra2), 32'd9);
        @(posedge clk); #1 reset = 1'b0;

        // add f3 = f1 + f2, EU latency 3
        run("add", 3'b000, 5'd1, 5'd2, 5'd3, 3, 32'h4040_0000, 5'b0, 1'b0,
            5, 1, 1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        // mov f4 = f1
        run("mov", 3'b100, 5'd1, 5'd0, 5'd4, 0, 32'h0, 5'b0, 1'b0,
            2, 0, 1, 32'h0, 32'h0, 32'h3F80_0000);
        // cmp_lt returning 1, then 0
        run("cmp1", 3'b101, 5'd1, 5'd2, 5'd0, 1, 32'h0000_0001, 5'b0, 1'b0,
            3, 1, 0, 32'h3F80_0000, 32'h4000_0000, 32'h0);
        chk("fcc_after_cmp1", 32'(fcc), 32'd1);
        run("cmp0", 3'b101, 5'd2, 5'd1, 5'd0, 2, 32'h0000_0000, 5'b0, 1'b0,
            4, 1, 0, 32'h4000_0000, 32'h3F80_0000, 32'h0);
        chk("fcc_after_cmp0", 32'(fcc), 32'd0);
        // sticky flag accumulation across div then add
        run("div", 3'b011, 5'd2, 5'd1, 5'd5, 2, 32'h4000_0000, 5'b01000, 1'b0,
            4, 1, 1, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000);
        run("add2", 3'b000, 5'd3, 5'd4, 5'd6, 1, 32'h4080_0000, 5'b00001, 1'b0,
            3, 1, 1, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000);
        chk("sticky_accum", 32'(sticky_flags), 32'b01001);
        pulse_clr();
        chk("sticky_cleared", 32'(sticky_flags), 32'd0);
        // eu_done while idle must not touch the flags
        @(posedge clk); #1 eu_done = 1'b1; eu_flags = 5'b11111;
        @(posedge clk); #1 eu_done = 1'b0; eu_flags = 5'b0;
        chk("idle_done_ignored", 32'(sticky_flags), 32'd0);
        // fd == fs: sub f1 = f1 - f2, then read f1 back through mov
        run("sub_fd_eq_fs", 3'b001, 5'd1, 5'd2, 5'd1, 4, 32'hBF80_0000, 5'b10000, 1'b0,
            6, 1, 1, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000);
        run("mov_f1", 3'b100, 5'd1, 5'd0, 5'd7, 0, 32'h0, 5'b0, 1'b0,
            2, 0, 1, 32'h0, 32'h0, 32'hBF80_0000);
        chk("sticky_invalid", 32'(sticky_flags), 32'b10000);
        // clear coinciding with a flag update keeps only the new flags
        run("mul_clr", 3'b010, 5'd2, 5'd2, 5'd8, 2, 32'h4080_0000, 5'b00100, 1'b1,
            4, 1, 1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        chk("clr_then_or", 32'(sticky_flags), 32'b00100);
        // illegal ops
        run("ill110", 3'b110, 5'd1, 5'd2, 5'd9, 0, 32'h0, 5'b0, 1'b0,
            2, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("err_illegal_set", 32'(err_illegal), 32'd1);
        run("ill111", 3'b111, 5'd1, 5'd2, 5'd9, 0, 32'h0, 5'b0, 1'b0,
            2, 0, 0, 32'h0, 32'h0, 32'h0);
        pulse_clr();
        chk("err_illegal_cleared", 32'(err_illegal), 32'd0);
        chk("sticky_cleared2", 32'(sticky_flags), 32'd0);

        // reset in the middle of EXEC
        eu_q.push_back('{3'b000, 32'hBF80_0000, 32'h4000_0000});
        @(posedge clk); #1;
        issue_valid = 1'b1; issue_op = 3'b000;
        issue_fs = 5'd1; issue_ft = 5'd2; issue_fd = 5'd10;
        @(posedge clk); #1 issue_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_exec_stall", 32'(stall), 32'd1);
        @(negedge clk); #1 reset = 1'b1;
        #1;
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_eu_start", 32'(eu_start), 32'd0);
        chk("async_rst_eu_a", eu_a, 32'd0);
        chk("async_rst_eu_b", eu_b, 32'd0);
        chk("async_rst_eu_op", 32'(eu_op), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        eu_done = 1'b1; eu_result = 32'h1234_5678; eu_flags = 5'b11111;
        @(posedge clk); #1 eu_done = 1'b0; eu_flags = 5'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_rf_we", 32'(rf_we), 32'd0);
            chk("post_rst_stall", 32'(stall), 32'd0);
        end
        chk("post_rst_sticky", 32'(sticky_flags), 32'd0);

        chk("eu_queue_drained", 32'(eu_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
